piezo_seq: RTL and testbench

PIEZO_SEQ -- requirements
Module: piezo_seq

---
 rtl/piezo_seq.sv | 135 +++++++++++++
 tb/tb_piezo_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/piezo_seq.sv
// Piezo tune sequencer: arbitrates fanfare / battery-low / overspeed tunes and emits PWM period/duty per note.
// Optional battery-low tune is compiled in with `define PIEZO_BATT_LOW_EN.
module piezo_seq #(
  parameter int DUR_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_fanfare,
  input  logic        req_too_fast,
  input  logic        req_batt_low,
  output logic [28:0] period,
  output logic [28:0] duty,
  output logic        tone_en,
  output logic        busy,
  output logic [1:0]  tune_id
);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_FAN  = 2'd1;
  localparam logic [1:0] T_BATT = 2'd2;
  localparam logic [1:0] T_FAST = 2'd3;

  localparam logic [24:0] NOTE_LEN = 25'((32'd1 << 23) >> DUR_SHIFT);
  localparam logic [24:0] LAST_LEN = 25'((32'd1 << 24) >> DUR_SHIFT);
  localparam logic [24:0] GAP_LEN  = 25'((32'd1 << 22) >> DUR_SHIFT);

  state_t      state_q, state_d;
  logic [1:0]  tune_q, tune_d;
  logic [1:0]  idx_q, idx_d;
  logic [24:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        batt_req;
  logic        last_note;
  logic [24:0] note_len;

`ifdef PIEZO_BATT_LOW_EN
  assign batt_req = req_batt_low;
`else
  logic unused_batt;
  assign unused_batt = req_batt_low;
  assign batt_req    = 1'b0;
`endif

  // Ascending G6,C7,E7,G7 table; battery-low walks it backwards.
  function automatic logic [28:0] note_period(input logic [1:0] tune, input logic [1:0] idx);
    logic [1:0] i;
    i = (tune == T_BATT) ? (2'd3 - idx) : idx;
    case (i)
      2'd0:    note_period = 29'd31888;
      2'd1:    note_period = 29'd23889;
      2'd2:    note_period = 29'd18961;
      default: note_period = 29'd15944;
    endcase
  endfunction

  assign last_note = (tune_q == T_FAST) ? (idx_q == 2'd2) : (idx_q == 2'd3);
  assign note_len  = last_note ? LAST_LEN : NOTE_LEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tune_q  <= T_NONE;
      idx_q   <= 2'd0;
      cnt_q   <= 25'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tune_q  <= tune_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tune_d  = tune_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 25'd1;
    pend_d  = pend_q | req_fanfare;
    case (state_q)
      IDLE: begin
        cnt_d = 25'd0;
        idx_d = 2'd0;
        if (req_too_fast) begin
          state_d = NOTE;
          tune_d  = T_FAST;
        end else if (batt_req) begin
          state_d = NOTE;
          tune_d  = T_BATT;
        end else if (pend_q || req_fanfare) begin
          state_d = NOTE;
          tune_d  = T_FAN;
          pend_d  = 1'b0;
        end
      end
      NOTE, GAP: begin
        if (req_too_fast && tune_q != T_FAST) begin
          // Overspeed wins immediately; an interrupted fanfare is replayed later.
          state_d = NOTE;
          tune_d  = T_FAST;
          idx_d   = 2'd0;
          cnt_d   = 25'd0;
          if (tune_q == T_FAN) pend_d = 1'b1;
        end else if (state_q == NOTE) begin
          if (cnt_q == note_len - 25'd1) begin
            cnt_d = 25'd0;
            if (last_note) state_d = GAP;
            else           idx_d   = idx_q + 2'd1;
          end
        end else if (cnt_q == GAP_LEN - 25'd1) begin
          state_d = IDLE;
          tune_d  = T_NONE;
          idx_d   = 2'd0;
          cnt_d   = 25'd0;
        end
      end
      default: begin
        state_d = IDLE;
        tune_d  = T_NONE;
        idx_d   = 2'd0;
        cnt_d   = 25'd0;
      end
    endcase
  end

  assign tone_en = (state_q == NOTE);
  assign busy    = (state_q != IDLE);
  assign tune_id = tune_q;
  assign period  = tone_en ? note_period(tune_q, idx_q) : 29'd0;
  assign duty    = period >> 1;

endmodule

// File: tb/tb_piezo_seq.sv
// Directed bench for piezo_seq at DUR_SHIFT=16 (note 128, last note 256, gap 64 clocks).
module tb_piezo_seq;

  logic        clk;
  logic        rst_n;
  logic        req_fanfare;
  logic        req_too_fast;
  logic        req_batt_low;
  logic [28:0] period;
  logic [28:0] duty;
  logic        tone_en;
  logic        busy;
  logic [1:0]  tune_id;

  int checks = 0;
  int errors = 0;

  piezo_seq #(.DUR_SHIFT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_fanfare(req_fanfare), .req_too_fast(req_too_fast),
    .req_batt_low(req_batt_low), .period(period), .duty(duty), .tone_en(tone_en),
    .busy(busy), .tune_id(tune_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_fanfare = 1'b0; req_too_fast = 1'b0; req_batt_low = 1'b0;
    #23;
    checks++; if ({period, duty, tone_en, busy, tune_id} !== 62'd0) begin
      errors++; $display("FAIL reset_outputs got p=%0d d=%0d t=%0b b=%0b id=%0d exp all 0", period, duty, tone_en, busy, tune_id);
    end
    step(1); rst_n = 1'b1; step(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%0b exp 0", busy); end
  endtask

  task automatic test_fanfare;
    req_fanfare = 1'b1; step(1); req_fanfare = 1'b0;
    checks++; if (period !== 29'd31888 || duty !== 29'd15944 || tune_id !== 2'd1 || tone_en !== 1'b1) begin
      errors++; $display("FAIL fan_g6 p=%0d d=%0d id=%0d t=%0b exp 31888 15944 1 1", period, duty, tune_id, tone_en);
    end
    step(127);
    checks++; if (period !== 29'd31888) begin errors++; $display("FAIL fan_g6_end p=%0d exp 31888", period); end
    step(1);
    checks++; if (period !== 29'd23889 || duty !== 29'd11944) begin errors++; $display("FAIL fan_c7 p=%0d d=%0d exp 23889 11944", period, duty); end
    step(128);
    checks++; if (period !== 29'd18961) begin errors++; $display("FAIL fan_e7 p=%0d exp 18961", period); end
    step(128);
    checks++; if (period !== 29'd15944) begin errors++; $display("FAIL fan_g7 p=%0d exp 15944", period); end
    step(255);
    checks++; if (period !== 29'd15944 || tone_en !== 1'b1) begin errors++; $display("FAIL fan_g7_end p=%0d t=%0b exp 15944 1", period, tone_en); end
    step(1);
    checks++; if (tone_en !== 1'b0 || period !== 29'd0 || duty !== 29'd0 || busy !== 1'b1 || tune_id !== 2'd1) begin
      errors++; $display("FAIL fan_gap t=%0b p=%0d d=%0d b=%0b id=%0d exp 0 0 0 1 1", tone_en, period, duty, busy, tune_id);
    end
    step(63);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fan_gap_end busy=%0b exp 1", busy); end
    step(1);
    checks++; if (busy !== 1'b0 || tune_id !== 2'd0) begin errors++; $display("FAIL fan_idle b=%0b id=%0d exp 0 0", busy, tune_id); end
    step(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fan_no_replay busy=%0b exp 0", busy); end
  endtask

  task automatic test_too_fast;
    req_too_fast = 1'b1; step(1);
    checks++; if (period !== 29'd31888 || tune_id !== 2'd3) begin errors++; $display("FAIL tf_g6 p=%0d id=%0d exp 31888 3", period, tune_id); end
    step(128);
    checks++; if (period !== 29'd23889) begin errors++; $display("FAIL tf_c7 p=%0d exp 23889", period); end
    step(128);
    checks++; if (period !== 29'd18961) begin errors++; $display("FAIL tf_e7 p=%0d exp 18961", period); end
    step(256);
    checks++; if (tone_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tf_gap t=%0b b=%0b exp 0 1", tone_en, busy); end
    step(64);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tf_idle busy=%0b exp 0", busy); end
    step(1);
    checks++; if (period !== 29'd31888 || tune_id !== 2'd3) begin errors++; $display("FAIL tf_repeat p=%0d id=%0d exp 31888 3", period, tune_id); end
    step(128);
    req_too_fast = 1'b0;
    checks++; if (period !== 29'd23889) begin errors++; $display("FAIL tf_drop_c7 p=%0d exp 23889", period); end
    step(128);
    checks++; if (period !== 29'd18961) begin errors++; $display("FAIL tf_drop_e7 p=%0d exp 18961", period); end
    step(256);
    checks++; if (tone_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tf_drop_gap t=%0b b=%0b exp 0 1", tone_en, busy); end
    step(64);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tf_drop_idle busy=%0b exp 0", busy); end
    step(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tf_stays_idle busy=%0b exp 0", busy); end
  endtask

  task automatic test_preempt;
    req_fanfare = 1'b1; step(1); req_fanfare = 1'b0;
    step(256);
    checks++; if (period !== 29'd18961) begin errors++; $display("FAIL pre_fan_e7 p=%0d exp 18961", period); end
    step(10);
    req_too_fast = 1'b1; step(1); req_too_fast = 1'b0;
    checks++; if (period !== 29'd31888 || tune_id !== 2'd3) begin errors++; $display("FAIL pre_tf p=%0d id=%0d exp 31888 3", period, tune_id); end
    step(512);
    checks++; if (tone_en !== 1'b0 || tune_id !== 2'd3) begin errors++; $display("FAIL pre_tf_gap t=%0b id=%0d exp 0 3", tone_en, tune_id); end
    step(64);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pre_idle busy=%0b exp 0", busy); end
    step(1);
    checks++; if (period !== 29'd31888 || tune_id !== 2'd1) begin errors++; $display("FAIL pre_replay p=%0d id=%0d exp 31888 1", period, tune_id); end
    step(704);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pre_replay_done busy=%0b exp 0", busy); end
    step(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pre_pend_clear busy=%0b exp 0", busy); end
  endtask

`ifdef PIEZO_BATT_LOW_EN
  task automatic test_batt_priority;
    req_fanfare = 1'b1; req_batt_low = 1'b1; step(1); req_fanfare = 1'b0; req_batt_low = 1'b0;
    checks++; if (period !== 29'd15944 || tune_id !== 2'd2) begin errors++; $display("FAIL bl_first p=%0d id=%0d exp 15944 2", period, tune_id); end
    step(128);
    checks++; if (period !== 29'd18961) begin errors++; $display("FAIL bl_e7 p=%0d exp 18961", period); end
    step(256);
    checks++; if (period !== 29'd31888) begin errors++; $display("FAIL bl_g6 p=%0d exp 31888", period); end
    step(256);
    checks++; if (tone_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bl_gap t=%0b b=%0b exp 0 1", tone_en, busy); end
    step(64);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bl_idle busy=%0b exp 0", busy); end
    step(1);
    checks++; if (period !== 29'd31888 || tune_id !== 2'd1) begin errors++; $display("FAIL bl_then_fan p=%0d id=%0d exp 31888 1", period, tune_id); end
    step(704);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bl_fan_done busy=%0b exp 0", busy); end
  endtask
`else
  task automatic test_no_batt;
    req_batt_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++; if (busy !== 1'b0 || tune_id !== 2'd0) begin
        errors++; $display("FAIL nobatt_cyc%0d b=%0b id=%0d exp 0 0", i, busy, tune_id);
      end
    end
    req_batt_low = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    req_fanfare = 1'b1; step(1); req_fanfare = 1'b0;
    step(50);
    req_fanfare = 1'b1; step(1); req_fanfare = 1'b0;
    checks++; if (tone_en !== 1'b1) begin errors++; $display("FAIL rst_mid_playing t=%0b exp 1", tone_en); end
    rst_n = 1'b0; #1;
    checks++; if ({period, duty, tone_en, busy, tune_id} !== 62'd0) begin
      errors++; $display("FAIL rst_mid_outputs p=%0d d=%0d t=%0b b=%0b id=%0d exp all 0", period, duty, tone_en, busy, tune_id);
    end
    step(2); rst_n = 1'b1;
    step(20);
    checks++; if (busy !== 1'b0 || tune_id !== 2'd0) begin errors++; $display("FAIL rst_mid_forgot b=%0b id=%0d exp 0 0", busy, tune_id); end
  endtask

  initial begin
    test_reset;
    test_fanfare;
    test_too_fast;
    test_preempt;
`ifdef PIEZO_BATT_LOW_EN
    test_batt_priority;
`else
    test_no_batt;
`endif
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
